// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader
//   Streams a configuration bitstream into NUM_CHAINS parallel configuration
//   chains. Holds the fabric configuration reset for RST_CYCLES cycles, then
//   accepts one word per bs_valid & bs_ready cycle and issues one registered
//   shift per accepted word. While shifting, any set bit on ccff_tail
//   raises the sticky tail_err flag.
// Ports
//   prog_clk, pReset_n        programming clock, async active-low reset
//   start                     one-cycle load request (honoured in IDLE/DONE)
//   bs_data/bs_valid/bs_ready bitstream word handshake (ready only in LOAD)
//   ccff_head/ccff_shift_en   serial data and shift strobe to chain heads
//   ccff_tail                 serial data from chain tails (leftover check)
//   fab_pReset/config_enable  fabric configuration reset and mode
//   busy/done/tail_err        status; done held until next start
//   shift_cnt                 shifts issued in the current load
module ccff_bitstream_loader #(
   parameter int unsigned NUM_CHAINS = 12,
   parameter int unsigned CHAIN_LEN  = 2048,
   parameter int unsigned RST_CYCLES = 4,
   parameter int unsigned CNT_W      = 12
) (
   input  logic                  prog_clk,
   input  logic                  pReset_n,
   input  logic                  start,
   input  logic [NUM_CHAINS-1:0] bs_data,
   input  logic                  bs_valid,
   output logic                  bs_ready,
   output logic [NUM_CHAINS-1:0] ccff_head,
   output logic                  ccff_shift_en,
   input  logic [NUM_CHAINS-1:0] ccff_tail,
   output logic                  fab_pReset,
   output logic                  config_enable,
   output logic                  busy,
   output logic                  done,
   output logic                  tail_err,
   output logic [CNT_W-1:0]      shift_cnt
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CLR   = 3'd1;
   localparam logic [2:0] S_LOAD  = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam int unsigned     RST_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

   logic [2:0]            state, state_d;
   logic [RST_W-1:0]      rst_cnt, rst_cnt_d;
   logic [NUM_CHAINS-1:0] head_d;
   logic                  shift_en_d;
   logic                  fab_preset_d;
   logic                  config_enable_d;
   logic                  busy_d;
   logic                  done_d;
   logic                  tail_err_d;
   logic [CNT_W-1:0]      shift_cnt_d;
   logic                  accept;

   // Ready depends only on state, so it is constant for the whole LOAD phase
   assign bs_ready = (state == S_LOAD);
   assign accept   = bs_ready & bs_valid;

   // Next state and next registered outputs
   always_comb begin
      state_d         = state;
      rst_cnt_d       = rst_cnt;
      head_d          = ccff_head;
      shift_en_d      = 1'b0;
      fab_preset_d    = fab_pReset;
      config_enable_d = config_enable;
      busy_d          = busy;
      done_d          = done;
      // Leftover data check: sample tails on every cycle a shift is issued
      tail_err_d      = tail_err | (ccff_shift_en & (|ccff_tail));
      shift_cnt_d     = shift_cnt;

      case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d         = S_CLR;
               rst_cnt_d       = '0;
               head_d          = '0;
               fab_preset_d    = 1'b1;
               config_enable_d = 1'b1;
               busy_d          = 1'b1;
               done_d          = 1'b0;
               tail_err_d      = 1'b0;
               shift_cnt_d     = '0;
            end
         end
         S_CLR: begin
            if (rst_cnt == RST_LAST) begin
               state_d      = S_LOAD;
               fab_preset_d = 1'b0;
            end else begin
               rst_cnt_d = rst_cnt + RST_W'(1);
            end
         end
         S_LOAD: begin
            if (accept) begin
               head_d      = bs_data;
               shift_en_d  = 1'b1;
               shift_cnt_d = shift_cnt + CNT_W'(1);
               // shift_cnt still lags by one accept, so this is the final word
               if (shift_cnt == CNT_LAST) begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            state_d         = S_DONE;
            head_d          = '0;
            config_enable_d = 1'b0;
            busy_d          = 1'b0;
            done_d          = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers; fabric stays in reset after pReset_n
   always_ff @(posedge prog_clk or negedge pReset_n) begin
      if (!pReset_n) begin
         state         <= S_IDLE;
         rst_cnt       <= '0;
         ccff_head     <= '0;
         ccff_shift_en <= 1'b0;
         fab_pReset    <= 1'b1;
         config_enable <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         tail_err      <= 1'b0;
         shift_cnt     <= '0;
      end else begin
         state         <= state_d;
         rst_cnt       <= rst_cnt_d;
         ccff_head     <= head_d;
         ccff_shift_en <= shift_en_d;
         fab_pReset    <= fab_preset_d;
         config_enable <= config_enable_d;
         busy          <= busy_d;
         done          <= done_d;
         tail_err      <= tail_err_d;
         shift_cnt     <= shift_cnt_d;
      end
   end

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Testbench for ccff_bitstream_loader with a small chain (4 shifts, 2 reset
// cycles). A transaction-level model predicts every output each cycle; a
// few literal checks pin the head sequence, latencies and sticky flags.
module tb_ccff_bitstream_loader;

   localparam int unsigned NC = 12;
   localparam int unsigned CL = 4;
   localparam int unsigned RC = 2;
   localparam int unsigned CW = 12;

   logic          prog_clk = 1'b0;
   logic          pReset_n = 1'b0;
   logic          start    = 1'b0;
   logic [NC-1:0] bs_data  = '0;
   logic          bs_valid = 1'b0;
   logic [NC-1:0] ccff_tail = '0;
   logic          bs_ready;
   logic [NC-1:0] ccff_head;
   logic          ccff_shift_en;
   logic          fab_pReset;
   logic          config_enable;
   logic          busy;
   logic          done;
   logic          tail_err;
   logic [CW-1:0] shift_cnt;

   ccff_bitstream_loader #(
      .NUM_CHAINS(NC), .CHAIN_LEN(CL), .RST_CYCLES(RC), .CNT_W(CW)
   ) dut (
      .prog_clk(prog_clk), .pReset_n(pReset_n), .start(start),
      .bs_data(bs_data), .bs_valid(bs_valid), .bs_ready(bs_ready),
      .ccff_head(ccff_head), .ccff_shift_en(ccff_shift_en),
      .ccff_tail(ccff_tail), .fab_pReset(fab_pReset),
      .config_enable(config_enable), .busy(busy), .done(done),
      .tail_err(tail_err), .shift_cnt(shift_cnt)
   );

   always #5 prog_clk = ~prog_clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   bit            m_active   = 1'b0;  // a load is in progress (CLR..DRAIN)
   bit            m_fresh    = 1'b1;  // idle since reset: fabric held cleared
   bit            m_done     = 1'b0;
   bit            m_tail_err = 1'b0;
   bit            m_shift_en = 1'b0;
   int            m_clr_left = 0;     // reset cycles still to go
   int            m_accepts  = 0;
   int            m_shifts   = 0;
   logic [NC-1:0] m_head     = '0;

   initial forever begin
      @(posedge prog_clk or negedge pReset_n);
      if (!pReset_n) begin
         m_active = 1'b0; m_fresh = 1'b1; m_done = 1'b0; m_tail_err = 1'b0;
         m_shift_en = 1'b0; m_clr_left = 0; m_accepts = 0; m_shifts = 0;
         m_head = '0;
      end else begin
         if (m_shift_en && (ccff_tail != '0)) m_tail_err = 1'b1;
         m_shift_en = 1'b0;
         if (!m_active) begin
            if (start) begin
               m_active = 1'b1; m_fresh = 1'b0; m_done = 1'b0;
               m_tail_err = 1'b0; m_clr_left = RC; m_accepts = 0;
               m_shifts = 0; m_head = '0;
            end
         end else if (m_clr_left > 0) begin
            m_clr_left--;
         end else if (m_accepts < CL) begin
            if (bs_valid) begin
               m_accepts++; m_shifts++; m_head = bs_data; m_shift_en = 1'b1;
            end
         end else begin
            // all words shifted and the drain cycle has passed
            m_active = 1'b0; m_done = 1'b1; m_head = '0;
         end
      end
   end

   // ---------------- compare process + tail driver ----------------
   bit            chk_en     = 1'b0;
   int            tail_at    = 0;
   int            shift_seen = 0;
   int            pres_cnt   = 0;
   logic [NC-1:0] head_log[$];

   initial forever begin
      @(negedge prog_clk);
      if (chk_en) begin
         check("bs_ready", 32'(bs_ready),
               32'(m_active && m_clr_left == 0 && m_accepts < CL));
         check("ccff_head", 32'(ccff_head), 32'(m_head));
         check("ccff_shift_en", 32'(ccff_shift_en), 32'(m_shift_en));
         check("fab_pReset", 32'(fab_pReset), 32'(m_fresh || (m_active && m_clr_left > 0)));
         check("config_enable", 32'(config_enable), 32'(m_active));
         check("busy", 32'(busy), 32'(m_active));
         check("done", 32'(done), 32'(m_done));
         check("tail_err", 32'(tail_err), 32'(m_tail_err));
         check("shift_cnt", 32'(shift_cnt), 32'(m_shifts));
      end
      if (ccff_shift_en === 1'b1) head_log.push_back(ccff_head);
      if (busy === 1'b1 && fab_pReset === 1'b1) pres_cnt++;
      if (m_shift_en) begin
         shift_seen++;
         ccff_tail = (tail_at != 0 && shift_seen == tail_at) ? NC'(12'h010) : '0;
      end else begin
         ccff_tail = '0;
      end
   end

   // ---------------- stimulus ----------------
   logic [NC-1:0] words [CL] = '{12'h001, 12'h002, 12'h004, 12'h008};

   task automatic do_load(input bit gap, input bit mid_start, input int abort_after,
                          input int tail_cycle, input bit hold5);
      int  idx = 0;
      int  cyc = 0;
      bit  pulsed = 1'b0;
      bit  aborted = 1'b0;
      @(negedge prog_clk);
      head_log.delete();
      pres_cnt = 0; shift_seen = 0; tail_at = tail_cycle;
      start = 1'b1;
      @(negedge prog_clk);
      start = 1'b0;
      check("tail_err_cleared_on_start", 32'(tail_err), 32'd0);
      check("cfg_en_on_start", 32'(config_enable), 32'd1);
      while (idx < CL && cyc < 60 && !aborted) begin
         start = 1'b0;
         if (abort_after > 0 && m_shifts == abort_after) begin
            #2 pReset_n = 1'b0;
            bs_valid = 1'b0;
            #1;
            check("abort_busy", 32'(busy), 32'd0);
            check("abort_bs_ready", 32'(bs_ready), 32'd0);
            check("abort_fab_pReset", 32'(fab_pReset), 32'd1);
            check("abort_shift_cnt", 32'(shift_cnt), 32'd0);
            aborted = 1'b1;
         end else begin
            if (mid_start && idx == 2 && !pulsed) begin
               start = 1'b1;
               pulsed = 1'b1;
            end
            bs_valid = gap ? (cyc % 2 == 0) : 1'b1;
            bs_data  = words[idx];
            if (bs_valid && bs_ready) idx++;
            cyc++;
            @(negedge prog_clk);
         end
      end
      start = 1'b0;
      if (aborted) begin
         @(negedge prog_clk);
         pReset_n = 1'b1;
         return;
      end
      check("all_words_accepted", 32'(idx), 32'(CL));
      bs_valid = hold5;
      bs_data  = hold5 ? NC'(12'h0AA) : '0;
      cyc = 0;
      while (done !== 1'b1 && cyc < 20) begin
         @(negedge prog_clk);
         cyc++;
      end
      check("done_latency_after_drain", 32'(cyc), 32'd1);
      repeat (2) @(negedge prog_clk);
      check("done_held", 32'(done), 32'd1);
      check("final_shift_cnt", 32'(shift_cnt), 32'(CL));
      check("done_head_zero", 32'(ccff_head), 32'd0);
      check("cfg_en_off", 32'(config_enable), 32'd0);
      check("fab_reset_cycles", 32'(pres_cnt), 32'(RC));
      check("tail_err_final", 32'(tail_err), 32'(tail_cycle != 0));
      check("head_seq_len", 32'(head_log.size()), 32'(CL));
      for (int i = 0; i < CL && i < head_log.size(); i++)
         check("head_seq", 32'(head_log[i]), 32'(words[i]));
      bs_valid = 1'b0;
      bs_data  = '0;
   endtask

   initial begin
      @(posedge prog_clk);
      @(negedge prog_clk);
      chk_en = 1'b1;
      check("rst_fab_pReset", 32'(fab_pReset), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_bs_ready", 32'(bs_ready), 32'd0);
      check("rst_cfg_en", 32'(config_enable), 32'd0);
      check("rst_shift_cnt", 32'(shift_cnt), 32'd0);
      @(negedge prog_clk);
      pReset_n = 1'b1;
      repeat (2) @(negedge prog_clk);

      do_load(1'b0, 1'b0, 0, 0, 1'b0);  // continuous words
      do_load(1'b1, 1'b0, 0, 0, 1'b0);  // valid every other cycle
      do_load(1'b0, 1'b0, 0, 3, 1'b0);  // leftover tail data on 3rd shift
      do_load(1'b1, 1'b1, 0, 0, 1'b0);  // start ignored mid-load
      do_load(1'b0, 1'b0, 2, 0, 1'b0);  // reset after 2 shifts
      repeat (2) @(negedge prog_clk);
      check("post_abort_idle_done", 32'(done), 32'd0);
      do_load(1'b0, 1'b0, 0, 0, 1'b0);  // full reload after reset
      do_load(1'b0, 1'b0, 0, 0, 1'b1);  // 5th word offered, never taken

      repeat (2) @(negedge prog_clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      n_bad++;
      $display("FAIL global_timeout: simulation did not complete at %0t", $time);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
